// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_scan_ctrl display controller:
// scan state encoding, the blank pattern and the active-low hex segment table.
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the gfedcba active-low pattern for hex digit n (entry F first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_nibble_dec.sv
// Combinational hex nibble to active-low 7-segment (gfedcba) decoder.
module seg7_nibble_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_n_o
);

    // Straight table lookup; every nibble value has an entry.
    always_comb begin
        seg_n_o = SEG_TABLE[nib_i];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-synchronous update.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_q, pend_d, off_cap_q, off_cap_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d, frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

    logic                    frame_end_s, wr_fire_s, commit_s, digit_on_s, dp_sel_s;
    logic [3:0]              nib_s;
    logic [6:0]              dec_seg_s;

    assign frame_end_s = enable && (state_q == SHOW) && (cnt_q == DIGIT_LAST) && (idx_q == IDX_LAST);
    assign wr_fire_s   = wr_valid && !pend_q;
    // A value captured while dark is shown right away; otherwise it waits for the frame end.
    assign commit_s    = pend_q && (frame_end_s || off_cap_q);

    // Select the nibble and decimal point of the digit currently being scanned.
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_s    = disp_q[4*i +: 4];
                dp_sel_s = dp_q[i];
            end else begin
                nib_s    = nib_s;
                dp_sel_s = dp_sel_s;
            end
        end
    end

`ifdef SEG7_LZB_EN
    logic [IDX_W-1:0] hi_s;

    // Highest nonzero digit; digit 0 always counts as significant.
    always_comb begin
        hi_s = {IDX_W{1'b0}};
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                hi_s = IDX_W'(i);
            end else begin
                hi_s = hi_s;
            end
        end
    end

    assign digit_on_s = (idx_q <= hi_s);
`else
    assign digit_on_s = 1'b1;
`endif

    seg7_nibble_dec u_dec (
        .nib_i   (nib_s),
        .seg_n_o (dec_seg_s)
    );

    // Scan sequencer: state, digit index and dwell counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = OFF;
            idx_d   = {IDX_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                OFF: begin
                    state_d = BLANK;
                    idx_d   = {IDX_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == DIGIT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = {CNT_W{1'b0}};
                        idx_d   = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = OFF;
                    idx_d   = {IDX_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Pin values for the next cycle; enable is folded in so the display darkens immediately.
    always_comb begin
        seg_n_d      = SEG_BLANK;
        dp_n_d       = 1'b1;
        an_n_d       = {NUM_DIGITS{1'b1}};
        frame_tick_d = frame_end_s;
        if (enable && (state_q == SHOW) && digit_on_s) begin
            seg_n_d = dec_seg_s;
            dp_n_d  = ~dp_sel_s;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_n_d[i] = (idx_q != IDX_W'(i));
            end
        end else begin
            seg_n_d = SEG_BLANK;
            dp_n_d  = 1'b1;
            an_n_d  = {NUM_DIGITS{1'b1}};
        end
    end

    // Write port, pending buffer and committed display registers.
    always_comb begin
        pend_data_d = wr_fire_s ? wr_data : pend_data_q;
        pend_dp_d   = wr_fire_s ? wr_dp   : pend_dp_q;
        disp_d      = commit_s ? pend_data_q : disp_q;
        dp_d        = commit_s ? pend_dp_q   : dp_q;
        off_cap_d   = wr_fire_s && (state_q == OFF);
        if (wr_fire_s) begin
            pend_d = 1'b1;
        end else if (commit_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            idx_q        <= {IDX_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            disp_q       <= {(4*NUM_DIGITS){1'b0}};
            dp_q         <= {NUM_DIGITS{1'b0}};
            pend_data_q  <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q    <= {NUM_DIGITS{1'b0}};
            pend_q       <= 1'b0;
            off_cap_q    <= 1'b0;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_n_q       <= {NUM_DIGITS{1'b1}};
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            dp_q         <= dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            off_cap_q    <= off_cap_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign wr_ready   = ~pend_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-cycle digits and 1-cycle blanks.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, enable, wr_valid, wr_ready, dp_n, frame_tick;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp, an_n;
    logic [6:0]  seg_n;
    int          n_checks = 0;
    int          n_fail = 0;

`ifdef SEG7_LZB_EN
    localparam logic [3:0] ZERO_MASK = 4'b0001;
`else
    localparam logic [3:0] ZERO_MASK = 4'b1111;
`endif

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
        .frame_tick(frame_tick)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the first lit sample of digit 0; returns at the next frame's first lit sample.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps,
                               input logic [3:0] mask);
        logic [12:0] exp_v, got_v;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 5; c++) begin
                if (c < 4 && mask[d])
                    exp_v = {~(4'b0001 << d), segs[7*d +: 7], ~dps[d], 1'((d == 3) && (c == 3))};
                else
                    exp_v = {4'hF, 7'h7F, 1'b1, 1'((d == 3) && (c == 3))};
                got_v = {an_n, seg_n, dp_n, frame_tick};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s d%0d c%0d: {an,seg,dp,tick}=%h/%h/%b/%b required %h/%h/%b/%b",
                             name, d, c, got_v[12:9], got_v[8:2], got_v[1], got_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
                step();
            end
        end
    endtask

    task automatic wait_start();
        logic [3:0] prev;
        bit         found;
        found = 1'b0;
        prev  = an_n;
        for (int i = 0; i < 60; i++) begin
            step();
            if (prev == 4'hF && an_n == 4'hE) begin
                found = 1'b1;
                break;
            end
            prev = an_n;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_start: an_n=%h, required E after blank within 60 cycles", an_n);
        end
    endtask

    task automatic write_off(input logic [15:0] d, input logic [3:0] p);
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_idle_ready: wr_ready=%b required 1", wr_ready);
        end
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = p;
        step();
        wr_valid = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_capture: wr_ready=%b required 0", wr_ready);
        end
        step();
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_commit_off: wr_ready=%b required 1", wr_ready);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        wr_dp    = 4'h0;
        repeat (3) step();
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick, wr_ready} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: seg=%h dp=%b an=%h tick=%b rdy=%b required 7f 1 f 0 1",
                     seg_n, dp_n, an_n, frame_tick, wr_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({seg_n, an_n, wr_ready, dp_n, frame_tick} !== {7'h7F, 4'hF, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL idle cycle %0d: seg=%h an=%h rdy=%b required 7f f 1", i, seg_n, an_n, wr_ready);
            end
        end
    endtask

    task automatic test_scan();
        write_off(16'h12AF, 4'b0000);
        enable = 1'b1;
        wait_start();
        check_frame("scan_f1", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0000, 4'hF);
        check_frame("scan_f2", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0000, 4'hF);
    endtask

    task automatic test_back_to_back();
        bit seen;
        seen     = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'h3C04;
        wr_dp    = 4'b0010;
        fork
            check_frame("old_value", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0000, 4'hF);
            begin
                step();
                wr_data = 16'hE7D6;
                wr_dp   = 4'b1001;
                for (int i = 0; i < 25; i++) begin
                    if (frame_tick === 1'b1) begin
                        seen = 1'b1;
                        break;
                    end
                    n_checks++;
                    if (wr_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL busy_ready: wr_ready=%b required 0", wr_ready);
                    end
                    step();
                end
                n_checks++;
                if (!seen || wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_at_tick: tick_seen=%b wr_ready=%b required 1 1", seen, wr_ready);
                end
                step();
                n_checks++;
                if (wr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL second_capture: wr_ready=%b required 0", wr_ready);
                end
                wr_valid = 1'b0;
            end
        join
        check_frame("new_value", {7'h30, 7'h46, 7'h40, 7'h19}, 4'b0010, 4'hF);
        check_frame("second_value", {7'h06, 7'h78, 7'h21, 7'h02}, 4'b1001, 4'hF);
    endtask

    task automatic test_enable_toggle();
        repeat (11) step();
        n_checks++;
        if ({an_n, seg_n} !== {4'hB, 7'h78}) begin
            n_fail++;
            $display("FAIL idx2_lit: an=%h seg=%h required b 78", an_n, seg_n);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({an_n, seg_n, dp_n, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL disabled %0d: an=%h seg=%h dp=%b required f 7f 1", i, an_n, seg_n, dp_n);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({an_n, seg_n} !== {4'hF, 7'h7F}) begin
                n_fail++;
                $display("FAIL restart_blank %0d: an=%h seg=%h required f 7f", i, an_n, seg_n);
            end
        end
        step();
        check_frame("restart", {7'h06, 7'h78, 7'h21, 7'h02}, 4'b1001, 4'hF);
    endtask

    task automatic test_lzb();
        enable = 1'b0;
        step();
        write_off(16'h0005, 4'b0000);
        enable = 1'b1;
        wait_start();
        check_frame("lzb_0005", {7'h40, 7'h40, 7'h40, 7'h12}, 4'b0000, ZERO_MASK);
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1;
        wr_data  = 16'h8888;
        wr_dp    = 4'hF;
        step();
        wr_valid = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_capture: wr_ready=%b required 0", wr_ready);
        end
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick, wr_ready} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: seg=%h dp=%b an=%h tick=%b rdy=%b required 7f 1 f 0 1",
                     seg_n, dp_n, an_n, frame_tick, wr_ready);
        end
        repeat (2) step();
        rst_n = 1'b1;
        wait_start();
        check_frame("after_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, ZERO_MASK);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_scan();
        test_back_to_back();
        test_enable_toggle();
        test_lzb();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
